// File: rtl/mul_radix4_seq.sv
// mul_radix4_seq: sequential signed multiply-accumulate, result = a * b + c.
// Radix-4 Booth recoding, one recoded digit of b per clock. WIDTH/2 RUN
// cycles followed by one DONE cycle. Start/busy/done handshake.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request, sampled when not busy or in the DONE cycle
//   a, b, c in   signed multiplicand, multiplier, addend (sampled with start)
//   busy    out  high in RUN and DONE
//   done    out  one-cycle pulse, result/ovf valid from this cycle
//   result  out  signed a*b + c, 2*WIDTH bits, exact
//   ovf     out  result does not fit in signed WIDTH bits
module mul_radix4_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               ovf
);

  localparam int unsigned AccW   = 2 * WIDTH + 2;
  localparam int unsigned Digits = WIDTH / 2;
  localparam int unsigned CntW   = (Digits > 1) ? $clog2(Digits) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Digits - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [AccW-1:0]    acc_q, acc_d;
  logic [AccW-1:0]    ma_q, ma_d;       // multiplicand pre-scaled by 4^i
  logic [WIDTH:0]     b_q, b_d;         // {b, 1'b0}, shifted right two bits per digit
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [AccW-1:0]    addend;
  logic [AccW-1:0]    acc_sum;
  logic [WIDTH:0]     sum_top;
  logic               accept;

  // Booth digit from the low three bits of the shifting multiplier window.
  always_comb begin
    addend = '0;
    case (b_q[2:0])
      3'b001, 3'b010: addend = ma_q;
      3'b011:         addend = ma_q << 1;
      3'b100:         addend = -(ma_q << 1);
      3'b101, 3'b110: addend = -ma_q;
      default:        addend = '0;
    endcase
  end

  assign acc_sum = acc_q + addend;
  // Upper WIDTH+1 bits must all match for the result to fit in WIDTH bits.
  assign sum_top = acc_sum[2*WIDTH-1:WIDTH-1];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ma_d     = ma_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    accept   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) accept = 1'b1;
      end
      StRun: begin
        acc_d = acc_sum;
        ma_d  = ma_q << 2;
        b_d   = {{2{b_q[WIDTH]}}, b_q[WIDTH:2]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d  = StDone;
          result_d = acc_sum[2*WIDTH-1:0];
          ovf_d    = !((&sum_top) || !(|sum_top));
          done_d   = 1'b1;
        end
      end
      StDone: begin
        if (start) accept = 1'b1;
        else       state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d = StRun;
      acc_d   = {{(WIDTH + 2){c[WIDTH-1]}}, c};
      ma_d    = {{(WIDTH + 2){a[WIDTH-1]}}, a};
      b_d     = {b, 1'b0};
      cnt_d   = '0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      ma_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ma_q     <= ma_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_mul_radix4_seq.sv
// Self-checking bench for mul_radix4_seq (WIDTH = 32): directed vector table,
// handshake/reset sequences, and a bounded random sweep against a
// 64-bit signed reference product.
module tb_mul_radix4_seq;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [W-1:0]   c = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           ovf;

  int checks = 0;
  int errors = 0;

  mul_radix4_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .c      (c),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    logic [2*W-1:0] res;
    logic           ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at posedge+1. Issues one operation and waits (bounded) for done.
  // lat counts clock edges including the one that samples start.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W-1:0] tc,
                        output int lat, output logic [2*W-1:0] r, output logic o);
    a = ta; b = tb; c = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
    r = result;
    o = ovf;
  endtask

  function automatic logic [2*W-1:0] ref_mac(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                             input logic [W-1:0] tc);
    logic signed [2*W-1:0] sa, sb, sc;
    sa = {{W{ta[W-1]}}, ta};
    sb = {{W{tb[W-1]}}, tb};
    sc = {{W{tc[W-1]}}, tc};
    return sa * sb + sc;
  endfunction

  function automatic logic ref_ovf(input logic [2*W-1:0] r);
    logic [W:0] top;
    top = r[2*W-1:W-1];
    return !(top == '0 || top == '1);
  endfunction

  function automatic logic [W-1:0] pick(input int unsigned sel);
    case (sel)
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int             lat;
    logic [2*W-1:0] r;
    logic           o;
    logic [2*W-1:0] prev;
    logic [2*W-1:0] r1, r2;
    int             nd, t1, t2, n;
    logic           busy_low, dropped;

    vecs[0]  = '{32'd3,         32'd3,         32'd1,         64'd10,                 1'b0};
    vecs[1]  = '{32'hFFFF_FFFD, 32'd3,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0};
    vecs[2]  = '{32'hFFFF_FFFB, 32'd2,         32'd0,         64'hFFFF_FFFF_FFFF_FFF6, 1'b0};
    vecs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         64'h0000_0000_8000_0000, 1'b1};
    vecs[4]  = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 64'h4000_0000_7FFF_FFFF, 1'b1};
    vecs[5]  = '{32'h8000_0000, 32'h8000_0000, 32'd0,         64'h4000_0000_0000_0000, 1'b1};
    vecs[6]  = '{32'd0,         32'd0,         32'd0,         64'd0,                  1'b0};
    vecs[7]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0,         64'h3FFF_FFFF_0000_0001, 1'b1};
    vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0,                  1'b0};
    vecs[9]  = '{32'h0001_0000, 32'h0000_8000, 32'd0,         64'h0000_0000_8000_0000, 1'b1};
    vecs[10] = '{32'h0001_0000, 32'hFFFF_8000, 32'd0,         64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[11] = '{32'h0000_1234, 32'h0000_5678, 32'h0000_0010, 64'h0000_0000_0626_0070, 1'b0};
    vecs[12] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 64'hC000_0000_7FFF_FFFF, 1'b1};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",   {63'd0, busy}, 64'd0);
    check("rst_done",   {63'd0, done}, 64'd0);
    check("rst_result", result,        64'd0);
    check("rst_ovf",    {63'd0, ovf},  64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, lat, r, o);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_ovf", i), {63'd0, o}, {63'd0, vecs[i].ovf});
      if (i == 0) begin
        check("latency", 64'(lat), 64'd17);
        @(posedge clk); #1;
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("done_width", {63'd0, done}, 64'd0);
      end
    end
    prev = vecs[12].res;

    // Start pulsed mid-RUN must be ignored
    a = 32'd3; b = 32'd3; c = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    a = 32'd7; b = 32'd7; c = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_result_midrun", result, prev);
    nd = 0; r1 = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        r1 = result;
      end
    end
    check("midrun_done_count", 64'(nd), 64'd1);
    check("midrun_result", r1, 64'd10);

    // Back-to-back: start held across DONE
    a = 32'hFFFF_FFFD; b = 32'd3; c = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    a = 32'd5; b = 32'd6; c = 32'd7;
    n = 1; nd = 0; t1 = 0; t2 = 0; r1 = '0; r2 = '0;
    busy_low = 1'b0; dropped = 1'b0;
    while (n < 60 && nd < 2) begin
      @(posedge clk); #1;
      n++;
      if (nd == 1 && !dropped) begin
        start = 1'b0;
        dropped = 1'b1;
      end
      if (!busy) busy_low = 1'b1;
      if (done) begin
        nd++;
        if (nd == 1) begin t1 = n; r1 = result; end
        else begin t2 = n; r2 = result; end
      end
    end
    start = 1'b0;
    check("b2b_done_count", 64'(nd), 64'd2);
    check("b2b_first_lat", 64'(t1), 64'd17);
    check("b2b_spacing", 64'(t2 - t1), 64'd17);
    check("b2b_busy_low", {63'd0, busy_low}, 64'd0);
    check("b2b_result1", r1, 64'hFFFF_FFFF_FFFF_FFF6);
    check("b2b_result2", r2, 64'd37);
    @(posedge clk); #1;
    check("b2b_idle_busy", {63'd0, busy}, 64'd0);
    check("b2b_done_low", {63'd0, done}, 64'd0);

    // Reset in the middle of RUN
    a = 32'h7FFF_FFFF; b = 32'd2; c = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy",   {63'd0, busy}, 64'd0);
    check("midrst_done",   {63'd0, done}, 64'd0);
    check("midrst_result", result,        64'd0);
    check("midrst_ovf",    {63'd0, ovf},  64'd0);
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("midrst_no_done", 64'(nd), 64'd0);
    check("midrst_idle", {63'd0, busy}, 64'd0);
    run_op(32'd3, 32'd3, 32'd1, lat, r, o);
    check("post_rst_result", r, 64'd10);

    // Random sweep with extremes mixed in
    for (int k = 0; k < 1000; k++) begin
      logic [W-1:0]   ra, rb, rc;
      logic [2*W-1:0] e;
      ra = pick($urandom_range(0, 9));
      rb = pick($urandom_range(0, 9));
      rc = pick($urandom_range(0, 9));
      e = ref_mac(ra, rb, rc);
      run_op(ra, rb, rc, lat, r, o);
      check($sformatf("rand%0d_result a=%h b=%h c=%h", k, ra, rb, rc), r, e);
      check($sformatf("rand%0d_ovf", k), {63'd0, o}, {63'd0, ref_ovf(e)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
